// File: rtl/avalon_mm_burst_master_if.sv
// Avalon-MM bus bundle between a burst master and the interconnect.
// Master drives request fields; slave returns stall and read data.
interface avalon_mm_burst_master_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 4
) ();
  logic [ADDR_W-1:0]   ADDRESS;
  logic                READ;
  logic                WRITE;
  logic [DATA_W-1:0]   WRITEDATA;
  logic [DATA_W/8-1:0] BYTEENABLE;
  logic [BURST_W-1:0]  BURSTCOUNT;
  logic                WAITREQUEST;
  logic [DATA_W-1:0]   READDATA;
  logic                READDATAVALID;

  modport master (
    output ADDRESS, READ, WRITE, WRITEDATA,
    output BYTEENABLE, BURSTCOUNT,
    input  WAITREQUEST, READDATA, READDATAVALID
  );

  modport slave (
    input  ADDRESS, READ, WRITE, WRITEDATA,
    input  BYTEENABLE, BURSTCOUNT,
    output WAITREQUEST, READDATA, READDATAVALID
  );
endinterface

// File: rtl/avalon_mm_burst_master.sv
// Avalon-MM burst master: single/burst reads and writes from a
// command plus beat-stream front end, with a no-progress watchdog.
module avalon_mm_burst_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                CLK,
  input  logic                RESET,
  avalon_mm_burst_master_if.master av,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_rnw,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [BURST_W-1:0]  cmd_len,
  input  logic [DATA_W/8-1:0] cmd_be,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic                done,
  output logic                err
);

  localparam int CW = BURST_W + 1;
  localparam int BW = DATA_W / 8;
  localparam int TW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] MAXB =
    CW'(1) << (BURST_W - 1);
  localparam logic [TW-1:0] TMO_LAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD_CMD, S_RD_DATA, S_DONE
  } state_t;

  state_t            r_state, w_state;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic              r_read, w_read;
  logic              r_write, w_write;
  logic [DATA_W-1:0] r_wdata, w_wdata;
  logic [BW-1:0]     r_be, w_be;
  logic [BURST_W-1:0] r_bc, w_bc;
  logic [CW-1:0]     r_len, w_len;
  logic [CW-1:0]     r_loaded, w_loaded;
  logic [CW-1:0]     r_acc, w_acc;
  logic [CW-1:0]     r_rcnt, w_rcnt;
  logic [TW-1:0]     r_tmo, w_tmo;
  logic              r_rd_valid, w_rd_valid;
  logic [DATA_W-1:0] r_rd_data, w_rd_data;
  logic              r_rd_last, w_rd_last;
  logic              r_done, w_done;
  logic              r_err, w_err;

  logic w_len_ok;
  logic w_busy;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_rd_beat;
  logic w_wr_load;
  logic w_prog;
  logic w_tmo_hit;

  assign w_len_ok = (cmd_len != '0) &&
                    ({1'b0, cmd_len} <= MAXB);
  assign w_busy   = (r_state == S_WR) ||
                    (r_state == S_RD_CMD) ||
                    (r_state == S_RD_DATA);
  assign w_wr_acc = (r_state == S_WR) && r_write &&
                    !av.WAITREQUEST;
  assign w_rd_acc = (r_state == S_RD_CMD) &&
                    !av.WAITREQUEST;
  assign w_rd_beat = av.READDATAVALID &&
                     ((r_state == S_RD_CMD) ||
                      (r_state == S_RD_DATA));
  assign w_prog   = w_wr_acc || w_rd_acc || w_rd_beat;
  assign w_tmo_hit = (TIMEOUT != 0) && w_busy &&
                     !w_prog && (r_tmo == TMO_LAST);

  assign cmd_ready = (r_state == S_IDLE);
  assign wr_ready  = (r_state == S_WR) &&
                     (!r_write || !av.WAITREQUEST) &&
                     (r_loaded < r_len) && !w_tmo_hit;
  assign w_wr_load = wr_valid && wr_ready;

  // Next state, next registered outputs and beat counters
  always_comb begin
    w_state    = r_state;
    w_addr     = r_addr;
    w_read     = r_read;
    w_write    = r_write;
    w_wdata    = r_wdata;
    w_be       = r_be;
    w_bc       = r_bc;
    w_len      = r_len;
    w_loaded   = r_loaded;
    w_acc      = r_acc;
    w_rcnt     = r_rcnt;
    w_tmo      = r_tmo;
    w_rd_valid = 1'b0;
    w_rd_data  = r_rd_data;
    w_rd_last  = 1'b0;
    w_done     = 1'b0;
    w_err      = 1'b0;
    if ((r_state == S_IDLE && cmd_valid) || w_prog)
      w_tmo = '0;
    else if (w_busy)
      w_tmo = r_tmo + 1'b1;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_len    = {1'b0, cmd_len};
          w_loaded = '0;
          w_acc    = '0;
          w_rcnt   = '0;
          if (!w_len_ok) begin
            w_state = S_DONE;
            w_done  = 1'b1;
            w_err   = 1'b1;
          end else begin
            w_addr = cmd_addr;
            w_be   = cmd_be;
            w_bc   = cmd_len;
            if (cmd_rnw) begin
              w_read  = 1'b1;
              w_state = S_RD_CMD;
            end else begin
              w_state = S_WR;
            end
          end
        end
      end
      S_WR: begin
        if (w_wr_load) begin
          w_wdata  = wr_data;
          w_write  = 1'b1;
          w_loaded = r_loaded + 1'b1;
        end else if (!r_write || w_wr_acc) begin
          w_write = 1'b0;
        end
        if (w_wr_acc) begin
          w_acc = r_acc + 1'b1;
          if (w_acc == r_len) begin
            w_write = 1'b0;
            w_state = S_DONE;
            w_done  = 1'b1;
          end
        end
      end
      S_RD_CMD, S_RD_DATA: begin
        if (w_rd_acc) begin
          w_read  = 1'b0;
          w_state = S_RD_DATA;
        end
        if (w_rd_beat) begin
          w_rd_valid = 1'b1;
          w_rd_data  = av.READDATA;
          w_rcnt     = r_rcnt + 1'b1;
          if (w_rcnt == r_len) begin
            w_rd_last = 1'b1;
            w_read    = 1'b0;
            w_state   = S_DONE;
            w_done    = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_addr  = '0;
        w_be    = '0;
        w_bc    = '0;
      end
      default: w_state = S_IDLE;
    endcase
    if (w_tmo_hit) begin
      w_read  = 1'b0;
      w_write = 1'b0;
      w_state = S_DONE;
      w_done  = 1'b1;
      w_err   = 1'b1;
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state;
  end

  // Registered bus outputs, stream outputs and counters
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_addr     <= '0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_bc       <= '0;
      r_len      <= '0;
      r_loaded   <= '0;
      r_acc      <= '0;
      r_rcnt     <= '0;
      r_tmo      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_last  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_addr     <= w_addr;
      r_read     <= w_read;
      r_write    <= w_write;
      r_wdata    <= w_wdata;
      r_be       <= w_be;
      r_bc       <= w_bc;
      r_len      <= w_len;
      r_loaded   <= w_loaded;
      r_acc      <= w_acc;
      r_rcnt     <= w_rcnt;
      r_tmo      <= w_tmo;
      r_rd_valid <= w_rd_valid;
      r_rd_data  <= w_rd_data;
      r_rd_last  <= w_rd_last;
      r_done     <= w_done;
      r_err      <= w_err;
    end
  end

  assign av.ADDRESS    = r_addr;
  assign av.READ       = r_read;
  assign av.WRITE      = r_write;
  assign av.WRITEDATA  = r_wdata;
  assign av.BYTEENABLE = r_be;
  assign av.BURSTCOUNT = r_bc;
  assign rd_valid      = r_rd_valid;
  assign rd_data       = r_rd_data;
  assign rd_last       = r_rd_last;
  assign done          = r_done;
  assign err           = r_err;

endmodule

// File: tb/tb_avalon_mm_burst_master.sv
// Bench for avalon_mm_burst_master: scoreboarded write/read bursts,
// illegal lengths, watchdog abort and mid-burst reset.
module tb_avalon_mm_burst_master;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BWD = 4;
  localparam int TMO = 16;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        cmd_valid, cmd_ready, cmd_rnw;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len, cmd_be;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_last, done, err;
  logic [31:0] rd_data;

  avalon_mm_burst_master_if #(
    .ADDR_W(AW), .DATA_W(DW), .BURST_W(BWD)
  ) av ();

  avalon_mm_burst_master #(
    .ADDR_W(AW), .DATA_W(DW),
    .BURST_W(BWD), .TIMEOUT(TMO)
  ) dut (
    .CLK(CLK), .RESET(RESET), .av(av),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rnw(cmd_rnw), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_be(cmd_be),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // scoreboard queues
  logic [31:0] exp_wq[$];
  logic [32:0] exp_rq[$];
  logic        exp_dq[$];
  logic [31:0] exp_addr;
  logic [3:0]  exp_bc, exp_be;

  int n_wacc = 0, n_racc = 0, n_done = 0;
  int n_whi = 0, n_bus = 0, n_rdv = 0;
  logic tb_hs = 1'b0;

  // write source feed
  logic [31:0] src_q[$];
  int          gap_q[$];
  int          src_gap = 0;

  // slave stall configuration
  int ws_cfg[8], ws_used[8];
  int rs_cfg = 0, rs_used = 0;

  // monitor: sample away from the active edge
  always @(negedge CLK) begin
    if (RESET) begin
      tb_hs = 1'b0;
    end else begin
      if (av.WRITE) n_whi++;
      if (av.READ || av.WRITE) n_bus++;
      if (av.WRITE && !av.WAITREQUEST) begin
        if (exp_wq.size() == 0) chk("wr_extra", 1, 0);
        else chk("wr_data", av.WRITEDATA,
                 exp_wq.pop_front());
        chk("wr_addr", av.ADDRESS, exp_addr);
        chk("wr_bc", av.BURSTCOUNT, exp_bc);
        chk("wr_be", av.BYTEENABLE, exp_be);
        n_wacc++;
      end
      if (av.READ && !av.WAITREQUEST) begin
        chk("rd_addr", av.ADDRESS, exp_addr);
        chk("rd_bc", av.BURSTCOUNT, exp_bc);
        n_racc++;
      end
      tb_hs = wr_valid && wr_ready;
      if (tb_hs) exp_wq.push_back(wr_data);
      if (rd_valid) begin
        n_rdv++;
        if (exp_rq.size() == 0) begin
          chk("rd_extra", 1, 0);
        end else begin
          logic [32:0] v;
          v = exp_rq.pop_front();
          chk("rd_data", rd_data, v[31:0]);
          chk("rd_last", rd_last, v[32]);
        end
      end
      if (done) begin
        n_done++;
        if (exp_dq.size() == 0) chk("done_extra", 1, 0);
        else chk("done_err", err, exp_dq.pop_front());
      end
    end
  end

  // slave waitrequest model
  initial begin
    av.WAITREQUEST = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (av.WRITE && n_wacc < 8 &&
          ws_used[n_wacc] < ws_cfg[n_wacc]) begin
        av.WAITREQUEST = 1'b1;
        ws_used[n_wacc]++;
      end else if (av.READ && rs_used < rs_cfg) begin
        av.WAITREQUEST = 1'b1;
        rs_used++;
      end else begin
        av.WAITREQUEST = 1'b0;
      end
    end
  end

  // write beat source with optional gaps
  initial begin
    wr_valid = 1'b0;
    wr_data  = '0;
    forever begin
      @(posedge CLK); #2;
      if (tb_hs && src_q.size() > 0) begin
        void'(src_q.pop_front());
        if (gap_q.size() > 0) void'(gap_q.pop_front());
        src_gap = (gap_q.size() > 0) ? gap_q[0] : 0;
      end
      if (src_gap > 0) begin
        wr_valid = 1'b0;
        src_gap--;
      end else if (src_q.size() > 0) begin
        wr_valid = 1'b1;
        wr_data  = src_q[0];
      end else begin
        wr_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic clr_stall();
    foreach (ws_cfg[i]) begin
      ws_cfg[i]  = 0;
      ws_used[i] = 0;
    end
    rs_cfg  = 0;
    rs_used = 0;
  endtask

  task automatic issue(input logic rnw,
                       input logic [31:0] a,
                       input logic [3:0] len,
                       input logic [3:0] be,
                       input logic e);
    int t;
    t = 0;
    exp_dq.push_back(e);
    exp_addr = a;
    exp_bc   = len;
    exp_be   = be;
    n_wacc   = 0;
    n_racc   = 0;
    cmd_valid = 1'b1;
    cmd_rnw   = rnw;
    cmd_addr  = a;
    cmd_len   = len;
    cmd_be    = be;
    @(negedge CLK);
    while (!cmd_ready && t < 20) begin
      @(negedge CLK);
      t++;
    end
    if (!cmd_ready) chk("cmd_ready_to", 0, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound,
                           output int t);
    int s;
    s = n_done;
    t = 0;
    while (n_done == s && t < bound) begin
      tick();
      t++;
    end
    chk("done_seen", n_done != s, 1);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_ctl"},
        {av.READ, av.WRITE, av.BYTEENABLE,
         av.BURSTCOUNT, rd_valid, rd_last,
         done, err}, 0);
    chk({tag, "_addr"}, av.ADDRESS, 0);
    chk({tag, "_wdata"}, av.WRITEDATA, 0);
    chk({tag, "_rdata"}, rd_data, 0);
    chk({tag, "_rdy"}, cmd_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1);
  end

  initial begin
    int t, b0, d0;
    RESET = 1'b1;
    cmd_valid = 1'b0;
    cmd_rnw = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    cmd_be = '0;
    av.READDATAVALID = 1'b0;
    av.READDATA = '0;
    clr_stall();
    repeat (3) tick();
    chk_rst("rst0");
    RESET = 1'b0;
    tick();

    // single write
    src_q.push_back(32'hDEADBEEF);
    gap_q.push_back(0);
    b0 = n_whi;
    issue(1'b0, 32'h100, 4'd1, 4'hF, 1'b0);
    wait_done(20, t);
    chk("sw_whi", n_whi - b0, 1);
    chk("sw_wacc", n_wacc, 1);

    // burst write with stalls and a source gap
    ws_cfg[1] = 3;
    ws_cfg[2] = 3;
    src_q = '{32'h11111111, 32'h22222222,
              32'h33333333, 32'h44444444};
    gap_q = '{0, 0, 2, 0};
    issue(1'b0, 32'h400, 4'd4, 4'h3, 1'b0);
    wait_done(60, t);
    chk("bw_wacc", n_wacc, 4);
    chk("bw_wq", exp_wq.size(), 0);
    clr_stall();

    // burst read with command stall and gapped data
    rs_cfg = 2;
    b0 = n_bus;
    d0 = n_rdv;
    issue(1'b1, 32'h2000, 4'd8, 4'hF, 1'b0);
    t = 0;
    while (n_racc == 0 && t < 20) begin
      tick();
      t++;
    end
    chk("br_racc", n_racc, 1);
    chk("br_read_drop", av.READ, 0);
    chk("br_read_cyc", n_bus - b0, 3);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] d;
      if (i % 3 == 1) tick();
      d = 32'hA5000000 + i * 32'h00010101;
      av.READDATAVALID = 1'b1;
      av.READDATA = d;
      exp_rq.push_back({(i == 7), d});
      tick();
      av.READDATAVALID = 1'b0;
    end
    wait_done(10, t);
    chk("br_beats", n_rdv - d0, 8);
    chk("br_rq", exp_rq.size(), 0);
    clr_stall();

    // illegal lengths: no bus activity, err
    b0 = n_bus;
    issue(1'b1, 32'h80, 4'd0, 4'hF, 1'b1);
    wait_done(2, t);
    issue(1'b0, 32'h80, 4'd9, 4'hF, 1'b1);
    wait_done(2, t);
    tick();
    chk("il_bus", n_bus - b0, 0);

    // watchdog on a read with no data
    d0 = n_rdv;
    issue(1'b1, 32'h3000, 4'd2, 4'hF, 1'b1);
    wait_done(40, t);
    chk("to_early", t >= 17, 1);
    chk("to_late", t <= 19, 1);
    av.READDATAVALID = 1'b1;
    av.READDATA = 32'h55AA55AA;
    tick();
    av.READDATAVALID = 1'b0;
    repeat (2) tick();
    chk("to_late_rdv", n_rdv - d0, 0);

    // reset in the middle of a write burst
    ws_cfg[2] = 50;
    src_q = '{32'hC0000001, 32'hC0000002,
              32'hC0000003, 32'hC0000004};
    gap_q = '{0, 0, 0, 0};
    issue(1'b0, 32'h500, 4'd4, 4'hC, 1'b0);
    t = 0;
    while (n_wacc < 2 && t < 30) begin
      tick();
      t++;
    end
    chk("rs_wacc", n_wacc, 2);
    tick();
    RESET = 1'b1;
    src_q.delete();
    gap_q.delete();
    src_gap = 0;
    tick();
    RESET = 1'b0;
    chk_rst("rst1");
    exp_wq.delete();
    exp_dq.delete();
    clr_stall();
    d0 = n_done;
    repeat (3) tick();
    chk("rs_nodone", n_done - d0, 0);
    src_q = '{32'h600D0001, 32'h600D0002};
    gap_q = '{0, 0};
    issue(1'b0, 32'h600, 4'd2, 4'hF, 1'b0);
    wait_done(20, t);
    chk("rs_new_wacc", n_wacc, 2);
    chk("rs_new_wq", exp_wq.size(), 0);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/avalon_mm_burst_master.md
Name: avalon_mm_burst_master

Overview:
Parametrised Avalon-MM master that runs single or burst read/write transactions from a simple command/stream control interface. It supports waitrequest stalls, pipelined read data via READDATAVALID, and a watchdog timeout. It sits between local control logic (DMA/test sequencers) and an Avalon-MM interconnect. It is the burst-capable, width-generic successor to the team's single-beat master.

Parameters:
ADDR_W, 32, address width (byte address)
DATA_W, 32, data width; multiple of 8
BURST_W, 4, BURSTCOUNT width; max burst MAXB = 2^(BURST_W-1) beats
TIMEOUT, 1024, cycles without progress before abort; 0 disables

Ports:
CLK  in  1  clock
RESET  in  1  sync active-high reset
ADDRESS  out  ADDR_W  Avalon address, held for whole burst
READ  out  1  Avalon read request
WRITE  out  1  Avalon write request
WRITEDATA  out  DATA_W  write beat data
BYTEENABLE  out  DATA_W/8  byte enables, held for whole burst
BURSTCOUNT  out  BURST_W  burst length
WAITREQUEST  in  1  slave stall
READDATA  in  DATA_W  read data
READDATAVALID  in  1  read data beat valid
cmd_valid  in  1  command request
cmd_ready  out  1  command accept (high only in IDLE)
cmd_rnw  in  1  1=read, 0=write
cmd_addr  in  ADDR_W  start address
cmd_len  in  BURST_W  beats, legal 1..MAXB
cmd_be  in  DATA_W/8  byte enables
wr_valid  in  1  write beat available
wr_ready  out  1  write beat consumed
wr_data  in  DATA_W  write beat
rd_valid  out  1  read beat out (no backpressure)
rd_data  out  DATA_W  read beat
rd_last  out  1  final beat of burst
done  out  1  one-cycle completion pulse
err  out  1  valid with done: illegal len or timeout

Behaviour:
- Interface: reset RESET, synchronous, active-high; clock CLK.
- All outputs are registered except cmd_ready and wr_ready. Reset values: all outputs 0. State IDLE, counters 0.
- States: IDLE, WR, RD_CMD, RD_DATA, DONE.
- IDLE: cmd_ready=1. Command accepted on cmd_valid. Addr, len, be and rnw are latched.
  - If cmd_len==0 or cmd_len>MAXB: go to DONE with err=1 and no bus activity.
  - Otherwise: drive ADDRESS, BYTEENABLE and BURSTCOUNT=len, then go to WR (rnw=0) or RD_CMD (rnw=1) with READ=1 set.
- WR: one-entry output register.
  - wr_ready = (state==WR) && (!WRITE || !WAITREQUEST) && (loaded<len).
  - A wr_valid&&wr_ready beat loads WRITEDATA, sets WRITE=1 and increments loaded.
  - If no new beat is loaded while the register is free, WRITE<=0 (gaps are legal).
  - Beat is accepted when WRITE && !WAITREQUEST; accepted count increments.
  - Acceptance of beat number len: WRITE<=0, go to DONE with err=0.
- RD_CMD: READ held high, with ADDRESS/BURSTCOUNT stable, until !WAITREQUEST. That cycle READ<=0 and the state goes to RD_DATA.
- RD_DATA: each READDATAVALID gives rd_valid=1 and rd_data=READDATA one cycle later. rd_last=1 on beat len. After beat len, go to DONE.
- READDATAVALID is counted in both RD_CMD and RD_DATA. It is ignored in IDLE, WR and DONE.
- DONE: done=1 for exactly one cycle, err as determined, then IDLE. ADDRESS, BYTEENABLE and BURSTCOUNT return to 0 in IDLE.
- Timeout (TIMEOUT>0): a progress counter resets on any command accept, beat accept, or READDATAVALID. Otherwise it increments in WR, RD_CMD and RD_DATA.
  - Reaching TIMEOUT: READ and WRITE deassert next cycle, go to DONE with err=1.
  - Remaining wr beats are not consumed. Late READDATAVALID is ignored.
- Counters are BURST_W+1 bits wide. Addresses do not increment; the slave increments within the burst.
- RESET mid-transaction: next cycle all outputs are 0 and state is IDLE. No done pulse. In-flight read data is dropped.

Test Plan:
- Single write: addr 0x100, len 1, be 0xF, data 0xDEADBEEF, WAITREQUEST low. Expect WRITE high 1 cycle with BURSTCOUNT=1, then done=1, err=0.
- Burst write len 4 with WAITREQUEST high on beats 2 and 3 for 3 cycles each, and a wr_valid gap. Expect 4 accepted beats in order, ADDRESS constant, then done.
- Burst read len 8 at 0x2000. WAITREQUEST stalls READ 2 cycles; READDATAVALID comes with gaps. Expect READ to drop after accept, 8 rd_valid beats with correct data, rd_last on 8th only, then done.
- cmd_len=0 and cmd_len=9 (BURST_W=4). Expect no READ/WRITE, done=1 and err=1 within 2 cycles.
- TIMEOUT=16, read with READDATAVALID never asserted. Expect done=1, err=1 after 16 idle cycles; later READDATAVALID gives no rd_valid.
- RESET asserted mid-burst after 2 of 4 write beats. Expect all outputs 0 next cycle and cmd_ready=1. A new command then completes normally.
